// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencer driving load/shift pulses into an N-bit rotating shift register
module shift_seq_ctrl #(
    parameter int N     = 8,
    parameter int DIV_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [N-1:0]     pattern,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    input  logic [1:0]       mode,
    output logic             sr_enable,
    output logic             sr_load,
    output logic             sr_dir,
    output logic [N-1:0]     sr_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int LEG_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LEG_W-1:0] LEG_LAST = LEG_W'(N - 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [DIV_W-1:0] per_m1_q, per_m1_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [LEG_W-1:0] leg_q, leg_d;
    logic             sr_enable_q, sr_enable_d;
    logic             sr_load_q, sr_load_d;
    logic             sr_dir_q, sr_dir_d;
    logic [N-1:0]     sr_in_q, sr_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic             zero_seq;
    logic             at_wrap;
    logic             finish;
    logic             turn;
    logic [LEG_W-1:0] leg_base;

    // presc_q counts cycles since the last load/shift pulse; a pulse is scheduled when it reaches P-1
    assign zero_seq = (steps_q == '0) || (mode_q == 2'b11);
    assign at_wrap  = (presc_q == per_m1_q);
    assign finish   = sr_enable_q && !sr_load_q && (step_cnt_q == steps_q);
    assign turn     = (N > 1) && (mode_q == 2'b10) && sr_enable_q && !sr_load_q
                      && (leg_q == LEG_LAST);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        steps_d     = steps_q;
        per_m1_d    = per_m1_q;
        presc_d     = presc_q;
        leg_d       = leg_q;
        sr_enable_d = 1'b0;
        sr_load_d   = 1'b0;
        sr_dir_d    = sr_dir_q;
        sr_in_d     = sr_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_cnt_d  = step_cnt_q;
        leg_base    = leg_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start && !stop) begin
                    sr_in_d     = pattern;
                    per_m1_d    = (period == '0) ? '0 : (period - DIV_W'(1));
                    steps_d     = steps;
                    mode_d      = mode;
                    step_cnt_d  = '0;
                    presc_d     = '0;
                    leg_d       = '0;
                    sr_enable_d = 1'b1;
                    sr_load_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_LOAD;
                end
            end

            S_LOAD, S_RUN: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if ((state_q == S_LOAD && zero_seq) || (state_q == S_RUN && finish)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    if (state_q == S_LOAD) begin
                        sr_dir_d = (mode_q != 2'b01);
                    end else if (turn) begin
                        sr_dir_d = ~sr_dir_q;
                        leg_base = '0;
                    end
                    // the turnaround takes effect from the cycle after the last pulse of a leg
                    if (at_wrap) begin
                        sr_enable_d = 1'b1;
                        presc_d     = '0;
                        step_cnt_d  = step_cnt_q + CNT_W'(1);
                        leg_d       = (mode_q == 2'b10) ? (leg_base + LEG_W'(1)) : leg_base;
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                        leg_d   = leg_base;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            steps_q     <= '0;
            per_m1_q    <= '0;
            presc_q     <= '0;
            leg_q       <= '0;
            sr_enable_q <= 1'b0;
            sr_load_q   <= 1'b0;
            sr_dir_q    <= 1'b1;
            sr_in_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            steps_q     <= steps_d;
            per_m1_q    <= per_m1_d;
            presc_q     <= presc_d;
            leg_q       <= leg_d;
            sr_enable_q <= sr_enable_d;
            sr_load_q   <= sr_load_d;
            sr_dir_q    <= sr_dir_d;
            sr_in_q     <= sr_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign sr_enable = sr_enable_q;
    assign sr_load   = sr_load_q;
    assign sr_dir    = sr_dir_q;
    assign sr_in     = sr_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl with a behavioural shift register
module tb_shift_seq_ctrl;

    localparam int N     = 8;
    localparam int DIV_W = 24;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             sys_rst_n;
    logic             start;
    logic             stop;
    logic [N-1:0]     pattern;
    logic [DIV_W-1:0] period;
    logic [CNT_W-1:0] steps;
    logic [1:0]       mode;
    logic             sr_enable;
    logic             sr_load;
    logic             sr_dir;
    logic [N-1:0]     sr_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_cnt;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .stop      (stop),
        .pattern   (pattern),
        .period    (period),
        .steps     (steps),
        .mode      (mode),
        .sr_enable (sr_enable),
        .sr_load   (sr_load),
        .sr_dir    (sr_dir),
        .sr_in     (sr_in),
        .busy      (busy),
        .done      (done),
        .step_cnt  (step_cnt)
    );

    // controlled marquee register: dir 1 = rotate right
    logic [N-1:0] sr_model;
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     sr_model <= '0;
        else if (sr_enable) sr_model <= sr_load ? sr_in :
                                        (sr_dir ? {sr_model[0], sr_model[N-1:1]}
                                                : {sr_model[N-2:0], sr_model[N-1]});
    end

    typedef struct packed {
        logic en;
        logic ld;
        logic bsy;
        logic dn;
        logic dir_v;
        logic dir;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic exp_dir(input int md, input int i);
        if (md == 1) return 1'b0;
        if (md == 2) return (((i - 1) / (N - 1)) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] rot(input logic [N-1:0] v, input logic right);
        return right ? {v[0], v[N-1:1]} : {v[N-2:0], v[N-1]};
    endfunction

    // builds the expected per-cycle timeline; t=1 is the cycle after the start edge
    task automatic push_exp(input logic [N-1:0] pat, input int p, input int s, input int md,
                            input int abort_t, output int t_end, output int n_steps,
                            output logic [N-1:0] fin_sr);
        int   pp, ss, done_t;
        bit   aborted;
        exp_t e;
        pp      = (p == 0) ? 1 : p;
        ss      = (md == 3) ? 0 : s;
        done_t  = 2 + ss * pp;
        aborted = (abort_t > 0) && (abort_t <= done_t - 1);
        t_end   = aborted ? abort_t + 2 : done_t + 1;
        n_steps = 0;
        fin_sr  = pat;
        for (int t = 1; t <= t_end; t++) begin
            e = '0;
            if ((!aborted || t <= abort_t) && t <= done_t - 1) begin
                e.bsy = 1'b1;
                if (t == 1) begin
                    e.en = 1'b1;
                    e.ld = 1'b1;
                end else if (((t - 1) % pp) == 0) begin
                    e.en    = 1'b1;
                    e.dir_v = 1'b1;
                    e.dir   = exp_dir(md, (t - 1) / pp);
                    n_steps++;
                    fin_sr  = rot(fin_sr, e.dir);
                end
            end
            if (!aborted && t == done_t) e.dn = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_seq(input string name, input logic [N-1:0] pat, input int p, input int s,
                           input int md, input int abort_t, input int ign_t);
        int           t_end, n_steps;
        logic [N-1:0] fin_sr;
        exp_t         e;
        push_exp(pat, p, s, md, abort_t, t_end, n_steps, fin_sr);
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        period  = DIV_W'(p);
        steps   = CNT_W'(s);
        mode    = 2'(md);
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check({name, "_queue_empty"}, 32'd1, 32'd0);
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_t%0d_ctl", name, t), {28'd0, sr_enable, sr_load, busy, done},
                  {28'd0, e.en, e.ld, e.bsy, e.dn});
            if (e.dir_v) check($sformatf("%s_t%0d_dir", name, t), {31'd0, sr_dir}, {31'd0, e.dir});
            start   = (t == ign_t);
            stop    = (t == abort_t);
            pattern = ~pat;
            period  = '1;
            steps   = '1;
            mode    = ~2'(md);
        end
        start = 1'b0;
        stop  = 1'b0;
        check({name, "_step_cnt"}, 32'(step_cnt), 32'(n_steps));
        check({name, "_sr_out"}, 32'(sr_model), 32'(fin_sr));
        check({name, "_sr_in"}, 32'(sr_in), 32'(pat));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pattern   = '0;
        period    = '0;
        steps     = '0;
        mode      = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {20'd0, sr_enable, sr_load, sr_dir, busy, done, 3'd0, step_cnt},
              {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
        check("rst_sr_in", 32'(sr_in), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq("rot_right", 8'h01, 3, 4, 0, 0, 0);
        run_seq("rot_left", 8'h01, 3, 4, 1, 0, 0);
        run_seq("ping_pong", 8'h01, 1, 10, 2, 0, 0);
        run_seq("zero_steps", 8'hA5, 3, 0, 0, 0, 0);
        run_seq("mode_hold", 8'hA5, 3, 5, 3, 0, 0);
        run_seq("period_zero", 8'h81, 0, 3, 1, 0, 0);
        run_seq("pp_long", 8'h03, 2, 16, 2, 0, 0);
        run_seq("abort", 8'h01, 2, 20, 0, 11, 6);
        run_seq("after_abort", 8'h11, 1, 2, 0, 0, 0);

        // asynchronous reset in the middle of a running sequence
        @(negedge clk);
        start   = 1'b1;
        pattern = 8'h3C;
        period  = DIV_W'(3);
        steps   = CNT_W'(10);
        mode    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {20'd0, sr_enable, sr_load, sr_dir, busy, done, 3'd0, step_cnt},
              {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
        check("async_rst_sr", {sr_in, sr_model}, 32'd0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, busy, sr_enable}, 32'd0);
        end
        run_seq("post_rst", 8'h01, 2, 3, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
